spi_multi_cntrl: RTL and testbench
==================================

SPI_MULTI_CNTRL -- requirements
Module: spi_multi_cntrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits (8..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter NUM_CS, default 4, number of chip-select outputs (>=2); CSW = clog2(NUM_CS).
REQ-004 SHALL have ports:
- clock  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a burst when idle.
- clk_ratio  in  8  SCLK half-period = clk_ratio+1 clocks.
- cpol  in  1  SCLK idle level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- cs_sel  in  CSW  target slave index.
- fifo_wren  in  1  push data_in to TX FIFO.
- data_in  in  DATA_W  TX word.
- data_full  out  1  TX FIFO full.
- data_empty  out  1  TX FIFO empty.
- fifo_count  out  clog2(FIFO_DEPTH)+1  TX FIFO occupancy.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at burst end.
- SEN  out  NUM_CS  active-low enables.
- SCLK  out  1  serial clock.
- SDATA  out  1  serial data out, MSB first.
- SDIN  in  1  serial data in.
- rx_data  out  DATA_W  last received word.
- rx_valid  out  1  one-cycle pulse per received word.

Function
REQ-005 SHALL accept a push when fifo_wren=1 and (not full, or a pop occurs the same cycle); a push when full without a pop is dropped, with contents unchanged.
REQ-006 SHALL implement FSM states IDLE, LOAD, SHIFT, GAP.
REQ-007 IDLE->LOAD when start=1 and data_empty=0; start with an empty FIFO is ignored.
REQ-008 On the IDLE->LOAD transition the block SHALL latch clk_ratio, cpol, cpha and cs_sel; later input changes have no effect until the next IDLE.
REQ-009 LOAD (1 cycle) SHALL pop one word into the shift register, drive SEN[latched cs_sel]=0 and, if cpha=0, drive SDATA=word MSB.
REQ-010 SHIFT SHALL produce 2*DATA_W SCLK edges, each spaced clk_ratio+1 clocks apart; SCLK starts and ends at cpol.
REQ-011 cpha=0: SDATA changes on trailing edges and SDIN is sampled on leading edges; cpha=1: SDATA changes on leading edges and SDIN is sampled on trailing edges.
REQ-012 At the end of a word, if the FIFO is non-empty the block SHALL go to LOAD with SEN held low (burst continuation); otherwise it goes to GAP.
REQ-013 GAP SHALL drive all SEN high for clk_ratio+1 clocks, then go to IDLE with done=1 for exactly one cycle.
REQ-014 busy SHALL be 1 in LOAD, SHIFT and GAP, and 0 in IDLE.
REQ-015 Only SEN[latched cs_sel] SHALL ever go low; all other SEN bits remain 1; SDATA=0 in IDLE.
REQ-016 Per-word SHIFT duration SHALL be 2*DATA_W*(clk_ratio+1) clocks; clk_ratio=0 gives SCLK=clock/2.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL range 0..FIFO_DEPTH.

Reset
REQ-018 On reset_n=0, immediately and asynchronously: FSM=IDLE, FIFO emptied (data_empty=1, data_full=0, fifo_count=0), SEN all 1, SCLK=0, SDATA=0, busy=0, done=0, rx_data=0, rx_valid=0.
REQ-019 Reset asserted mid-transfer SHALL abort the transfer without a done pulse; the FIFO contents are discarded.

Configuration
REQ-020 With macro SPI_MULTI_RX_EN defined, the block SHALL shift SDIN into a receive register per REQ-011 and, at each word end, load rx_data and pulse rx_valid for one cycle.
REQ-021 Without SPI_MULTI_RX_EN, SDIN SHALL be ignored and rx_data=0, rx_valid=0 permanently; the port list is identical in both builds.

Verification
REQ-022 Push 0xA5A5_0F0F, cs_sel=2, cpol=0, cpha=0, clk_ratio=1, start -> SEN=4'b1011 for the word, SDATA bits MSB-first sampled on rising SCLK, 128 clocks of SHIFT, done pulse after GAP.
REQ-023 Push 3 words, then start -> SEN[0] stays low across all 96 bits, exactly 3 pops, one done pulse, data_empty=1 at the end.
REQ-024 With FIFO_DEPTH=8, push 9 words with no start -> data_full=1, fifo_count=8, 9th word dropped; a later burst transmits only the first 8.
REQ-025 Modes 1/2/3 with loopback SDIN=SDATA and SPI_MULTI_RX_EN -> rx_data equals each transmitted word, rx_valid pulses once per word, SCLK idles at cpol.
REQ-026 Assert reset_n=0 at bit 10 of a word -> SEN=all 1 and SCLK=0 asynchronously, no done pulse, fifo_count=0.
REQ-027 start with an empty FIFO -> busy stays 0 and no SEN activity; with the FIFO full, simultaneous push and LOAD pop -> push accepted and fifo_count unchanged.

Source files
------------

// File: rtl/spi_multi_cntrl.sv
// SPI master with TX FIFO, multiple chip selects and burst continuation.
// Optional receive path enabled by defining SPI_MULTI_RX_EN.
module spi_multi_cntrl #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_CS     = 4,
    localparam int CSW       = $clog2(NUM_CS),
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        clk_ratio,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [CSW-1:0]    cs_sel,
    input  logic              fifo_wren,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_full,
    output logic              data_empty,
    output logic [AW:0]       fifo_count,
    output logic              busy,
    output logic              done,
    output logic [NUM_CS-1:0] SEN,
    output logic              SCLK,
    output logic              SDATA,
    input  logic              SDIN,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid
);

    localparam int EW = $clog2(2 * DATA_W);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    typedef struct packed {
        logic [7:0]     ratio;
        logic           cpol;
        logic           cpha;
        logic [CSW-1:0] cs;
    } cfg_t;

    state_t            state, state_nx;
    cfg_t              cfg;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic [DATA_W-1:0] head, tx_sr;
    logic [7:0]        div_cnt;
    logic [EW-1:0]     edge_cnt;
    logic              push, pop, launch, tick, leading, last_edge, shift_out;
    logic              sclk_q, sdata_q, done_q;

    assign head       = mem[rd_ptr];
    assign data_empty = (count == '0);
    assign data_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign fifo_count = count;
    assign pop        = (state == LOAD);
    // A full FIFO still accepts a word in the cycle the head is popped.
    assign push       = fifo_wren && (!data_full || pop);
    assign launch     = (state == IDLE) && (state_nx == LOAD);
    assign tick       = (div_cnt == cfg.ratio);
    assign leading    = ~edge_cnt[0];
    assign last_edge  = (state == SHIFT) && tick && (edge_cnt == EW'(2 * DATA_W - 1));
    assign shift_out  = cfg.cpha ? leading : !leading;

    assign busy  = (state != IDLE);
    assign done  = done_q;
    assign SCLK  = sclk_q;
    assign SDATA = sdata_q;
    assign SEN   = (state == LOAD || state == SHIFT) ? ~(NUM_CS'(1) << cfg.cs) : '1;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && !data_empty) state_nx = LOAD;
            LOAD:    state_nx = SHIFT;
            SHIFT:   if (last_edge) state_nx = data_empty ? GAP : LOAD;
            GAP:     if (tick) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cfg      <= '0;
            tx_sr    <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            sclk_q   <= 1'b0;
            sdata_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    sdata_q <= 1'b0;
                    div_cnt <= '0;
                    if (launch) begin
                        cfg    <= '{ratio: clk_ratio, cpol: cpol, cpha: cpha, cs: cs_sel};
                        sclk_q <= cpol;
                    end
                end
                LOAD: begin
                    tx_sr    <= head;
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                    if (!cfg.cpha) sdata_q <= head[DATA_W-1];
                end
                SHIFT: begin
                    if (tick) begin
                        div_cnt  <= '0;
                        edge_cnt <= edge_cnt + 1'b1;
                        sclk_q   <= ~sclk_q;
                        // cpha=0 already presented the MSB in LOAD, so it emits the next bit.
                        if (shift_out) begin
                            sdata_q <= cfg.cpha ? tx_sr[DATA_W-1] : tx_sr[DATA_W-2];
                            tx_sr   <= tx_sr << 1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    sdata_q <= 1'b0;
                    if (tick) begin
                        div_cnt <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: div_cnt <= '0;
            endcase
        end
    end

`ifdef SPI_MULTI_RX_EN
    logic [DATA_W-1:0] rx_sr, rx_next, rx_q;
    logic              rx_v, sample;

    assign rx_next  = {rx_sr[DATA_W-2:0], SDIN};
    assign sample   = (state == SHIFT) && tick && !shift_out;
    assign rx_data  = rx_q;
    assign rx_valid = rx_v;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_sr <= '0;
            rx_q  <= '0;
            rx_v  <= 1'b0;
        end else begin
            rx_v <= 1'b0;
            if (sample) rx_sr <= rx_next;
            // With cpha=1 the final sample lands on the word-ending edge itself.
            if (last_edge) begin
                rx_v <= 1'b1;
                rx_q <= cfg.cpha ? rx_next : rx_sr;
            end
        end
    end
`else
    logic unused_sdin;
    assign unused_sdin = SDIN;
    assign rx_data     = '0;
    assign rx_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_multi_cntrl.sv
// Randomized self-checking bench for spi_multi_cntrl; a negedge monitor
// decodes the SPI bus by mode rules and tasks compare against a word queue.
module tb_spi_multi_cntrl;

    localparam int DW  = 32;
    localparam int FD  = 8;
    localparam int NCS = 4;

    logic           clock = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic           cpol = 1'b0, cpha = 1'b0, fifo_wren = 1'b0;
    logic [7:0]     clk_ratio = '0;
    logic [1:0]     cs_sel = '0;
    logic [DW-1:0]  data_in = '0;
    logic           data_full, data_empty, busy, done, SCLK, SDATA, SDIN, rx_valid;
    logic [3:0]     fifo_count;
    logic [NCS-1:0] SEN;
    logic [DW-1:0]  rx_data;

    int n_checks = 0, n_fail = 0;

    spi_multi_cntrl #(.DATA_W(DW), .FIFO_DEPTH(FD), .NUM_CS(NCS)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .clk_ratio(clk_ratio),
        .cpol(cpol), .cpha(cpha), .cs_sel(cs_sel), .fifo_wren(fifo_wren),
        .data_in(data_in), .data_full(data_full), .data_empty(data_empty),
        .fifo_count(fifo_count), .busy(busy), .done(done), .SEN(SEN),
        .SCLK(SCLK), .SDATA(SDATA), .SDIN(SDIN), .rx_data(rx_data), .rx_valid(rx_valid)
    );

    assign SDIN = SDATA;   // loopback
    always #5 clock = ~clock;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // reference: words expected on the wire, in order, for the current burst
    logic [DW-1:0] exp_q[$];
    logic          m_cpol = 1'b0, m_cpha = 1'b0;
    int            m_cs = 0;

    // bus monitor
    int            cyc = 0, edges = 0, nbits = 0, obs_n = 0, rx_n = 0, done_cnt = 0;
    int            sen_low = 0, sen_fall = 0, busy_cnt = 0, sen_bad = 0, idle_bad = 0;
    int            rise_cyc = 0, gap_obs = 0;
    logic          sclk_prev = 1'b0, sen_prev_low = 1'b0;
    logic [DW-1:0] cur = '0;
    logic [DW-1:0] obs_w[64];
    logic [DW-1:0] rx_w[64];

    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            nbits = 0;
            sclk_prev = SCLK;
            sen_prev_low = 1'b0;
        end else begin
            if (SEN !== '1 && SEN !== ~(NCS'(1) << m_cs)) sen_bad++;
            if (!busy && SDATA !== 1'b0) idle_bad++;
            if (busy) busy_cnt++;
            if (SEN !== '1) begin
                sen_low++;
                if (!sen_prev_low) sen_fall++;
            end else if (sen_prev_low) begin
                rise_cyc = cyc;
            end
            if (sen_prev_low && SCLK !== sclk_prev) begin
                edges++;
                // leading edge leaves the idle level; cpha picks which edge samples
                if ((sclk_prev == m_cpol) == !m_cpha) begin
                    cur = {cur[DW-2:0], SDATA};
                    nbits++;
                    if (nbits == DW) begin
                        obs_w[obs_n % 64] = cur;
                        obs_n++;
                        nbits = 0;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                gap_obs = cyc - rise_cyc;
            end
            if (rx_valid) begin
                rx_w[rx_n % 64] = rx_data;
                rx_n++;
            end
            sclk_prev = SCLK;
            sen_prev_low = (SEN !== '1);
        end
    end

    task automatic push_word(input logic [DW-1:0] w);
        @(negedge clock);
        fifo_wren = 1'b1;
        data_in = w;
        if (exp_q.size() < FD) exp_q.push_back(w);
        @(negedge clock);
        fifo_wren = 1'b0;
    endtask

    // start a burst, then scramble the config inputs to prove they were latched
    task automatic go(input int r, input logic pol, input logic pha, input int cs);
        m_cpol = pol; m_cpha = pha; m_cs = cs;
        @(negedge clock);
        clk_ratio = 8'(r); cpol = pol; cpha = pha; cs_sel = 2'(cs); start = 1'b1;
        @(negedge clock);
        start = 1'b0; clk_ratio = 8'($urandom_range(0, 7)); cpol = ~pol; cpha = ~pha;
        cs_sel = 2'(cs + 1);
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (done_cnt == base && n < 20000) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++; if (SEN !== 4'b1111) begin n_fail++; $display("FAIL reset_sen: got %b want 1111", SEN); end
        n_checks++; if (SCLK !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", SCLK); end
        n_checks++; if (SDATA !== 1'b0) begin n_fail++; $display("FAIL reset_sdata: got %b want 0", SDATA); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
        n_checks++; if ({data_empty, data_full} !== 2'b10) begin n_fail++; $display("FAIL reset_flags: got %b want 10", {data_empty, data_full}); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_checks++; if (rx_data !== '0 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx: got %h/%b want 0/0", rx_data, rx_valid); end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++; if (busy !== 1'b0 || SEN !== 4'b1111) begin n_fail++; $display("FAIL post_reset_idle: busy %b SEN %b want 0 1111", busy, SEN); end
    endtask

    task automatic test_single;
        int ob = obs_n, db = done_cnt, sl = sen_low;
        push_word(32'hA5A5_0F0F);
        n_checks++; if (fifo_count !== 4'd1 || data_empty !== 1'b0) begin n_fail++; $display("FAIL single_push: count %0d empty %b want 1 0", fifo_count, data_empty); end
        go(1, 1'b0, 1'b0, 2);
        repeat (4) @(negedge clock);
        n_checks++; if (SEN !== 4'b1011) begin n_fail++; $display("FAIL single_sen: got %b want 1011", SEN); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        wait_done(db);
        n_checks++; if (done_cnt - db != 1) begin n_fail++; $display("FAIL single_done: got %0d pulses want 1", done_cnt - db); end
        n_checks++; if (sen_low - sl != 1 + 2 * DW * 2) begin n_fail++; $display("FAIL single_timing: SEN low %0d clocks want %0d", sen_low - sl, 1 + 2 * DW * 2); end
        n_checks++; if (gap_obs != 2) begin n_fail++; $display("FAIL single_gap: got %0d clocks want 2", gap_obs); end
        n_checks++; if (obs_n - ob != 1 || obs_w[ob % 64] !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL single_word: got %0d words, %h want 1, a5a50f0f", obs_n - ob, obs_w[ob % 64]); end
        n_checks++; if (SCLK !== 1'b0 || busy !== 1'b0 || data_empty !== 1'b1) begin n_fail++; $display("FAIL single_end: sclk %b busy %b empty %b want 0 0 1", SCLK, busy, data_empty); end
        exp_q.delete();
    endtask

    task automatic test_burst;
        int ob = obs_n, rb = rx_n, db = done_cnt, sl = sen_low, sf = sen_fall;
        int r = $urandom_range(0, 2);
        for (int i = 0; i < 3; i++) push_word($urandom);
        go(r, 1'b0, 1'b0, 0);
        wait_done(db);
        n_checks++; if (done_cnt - db != 1) begin n_fail++; $display("FAIL burst_done: got %0d pulses want 1", done_cnt - db); end
        n_checks++; if (sen_fall - sf != 1) begin n_fail++; $display("FAIL burst_sen_falls: got %0d want 1", sen_fall - sf); end
        n_checks++; if (sen_low - sl != 3 * (1 + 2 * DW * (r + 1))) begin n_fail++; $display("FAIL burst_sen_low: got %0d want %0d", sen_low - sl, 3 * (1 + 2 * DW * (r + 1))); end
        n_checks++; if (obs_n - ob != 3) begin n_fail++; $display("FAIL burst_count: got %0d words want 3", obs_n - ob); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (obs_w[(ob + i) % 64] !== exp_q[i]) begin n_fail++; $display("FAIL burst_word%0d: got %h want %h", i, obs_w[(ob + i) % 64], exp_q[i]); end
        end
`ifdef SPI_MULTI_RX_EN
        n_checks++; if (rx_n - rb != 3 || rx_w[rb % 64] !== exp_q[0]) begin n_fail++; $display("FAIL burst_rx: got %0d words first %h want 3 %h", rx_n - rb, rx_w[rb % 64], exp_q[0]); end
`else
        n_checks++; if (rx_n - rb != 0 || rx_data !== '0) begin n_fail++; $display("FAIL burst_rx_off: got %0d pulses data %h want 0 0", rx_n - rb, rx_data); end
`endif
        n_checks++; if (data_empty !== 1'b1) begin n_fail++; $display("FAIL burst_empty: got %b want 1", data_empty); end
        exp_q.delete();
    endtask

    task automatic test_full;
        int ob = obs_n, db = done_cnt;
        for (int i = 0; i < 9; i++) push_word($urandom);
        n_checks++; if (data_full !== 1'b1 || fifo_count !== 4'd8) begin n_fail++; $display("FAIL full_flags: full %b count %0d want 1 8", data_full, fifo_count); end
        go(0, 1'b0, 1'b0, 3);
        wait_done(db);
        n_checks++; if (obs_n - ob != FD) begin n_fail++; $display("FAIL full_count: got %0d words want %0d", obs_n - ob, FD); end
        for (int i = 0; i < FD; i++) begin
            n_checks++; if (obs_w[(ob + i) % 64] !== exp_q[i]) begin n_fail++; $display("FAIL full_word%0d: got %h want %h", i, obs_w[(ob + i) % 64], exp_q[i]); end
        end
        n_checks++; if (data_empty !== 1'b1 || fifo_count !== 4'd0) begin n_fail++; $display("FAIL full_drain: empty %b count %0d want 1 0", data_empty, fifo_count); end
        exp_q.delete();
    endtask

    task automatic test_modes;
        for (int m = 1; m < 4; m++) begin
            int ob = obs_n, rb = rx_n, db = done_cnt;
            logic pol = 1'(m >> 1);
            logic pha = 1'(m & 1);
            for (int i = 0; i < 2; i++) push_word($urandom);
            go($urandom_range(0, 3), pol, pha, $urandom_range(0, NCS - 1));
            wait_done(db);
            n_checks++; if (done_cnt - db != 1) begin n_fail++; $display("FAIL mode%0d_done: got %0d pulses want 1", m, done_cnt - db); end
            n_checks++; if (SCLK !== pol) begin n_fail++; $display("FAIL mode%0d_idle_sclk: got %b want %b", m, SCLK, pol); end
            for (int i = 0; i < 2; i++) begin
                n_checks++; if (obs_w[(ob + i) % 64] !== exp_q[i]) begin n_fail++; $display("FAIL mode%0d_word%0d: got %h want %h", m, i, obs_w[(ob + i) % 64], exp_q[i]); end
`ifdef SPI_MULTI_RX_EN
                n_checks++; if (rx_w[(rb + i) % 64] !== exp_q[i]) begin n_fail++; $display("FAIL mode%0d_rx%0d: got %h want %h", m, i, rx_w[(rb + i) % 64], exp_q[i]); end
`endif
            end
`ifdef SPI_MULTI_RX_EN
            n_checks++; if (rx_n - rb != 2) begin n_fail++; $display("FAIL mode%0d_rx_pulses: got %0d want 2", m, rx_n - rb); end
`else
            n_checks++; if (rx_n - rb != 0 || rx_data !== '0) begin n_fail++; $display("FAIL mode%0d_rx_off: got %0d pulses data %h want 0 0", m, rx_n - rb, rx_data); end
`endif
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid;
        int ob = obs_n, db = done_cnt, eb = edges, n = 0;
        for (int i = 0; i < 2; i++) push_word($urandom);
        go(1, 1'b0, 1'b0, $urandom_range(0, NCS - 1));
        while (edges - eb < 20 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        n_checks++; if (edges - eb < 20) begin n_fail++; $display("FAIL midrst_reach: got %0d edges want 20", edges - eb); end
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (SEN !== 4'b1111 || SCLK !== 1'b0) begin n_fail++; $display("FAIL midrst_async: SEN %b SCLK %b want 1111 0", SEN, SCLK); end
        n_checks++; if (busy !== 1'b0 || fifo_count !== 4'd0) begin n_fail++; $display("FAIL midrst_state: busy %b count %0d want 0 0", busy, fifo_count); end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (300) @(negedge clock);
        n_checks++; if (done_cnt != db) begin n_fail++; $display("FAIL midrst_done: got %0d pulses want 0", done_cnt - db); end
        n_checks++; if (obs_n != ob || busy !== 1'b0 || data_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_after: words %0d busy %b empty %b want 0 0 1", obs_n - ob, busy, data_empty); end
        exp_q.delete();
    endtask

    task automatic test_push_pop;
        int bb = busy_cnt, sf = sen_fall, ob, db;
        logic [DW-1:0] w9 = $urandom;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (10) @(negedge clock);
        n_checks++; if (busy_cnt != bb || sen_fall != sf) begin n_fail++; $display("FAIL empty_start: busy cycles %0d SEN falls %0d want 0 0", busy_cnt - bb, sen_fall - sf); end
        for (int i = 0; i < FD; i++) push_word($urandom);
        ob = obs_n; db = done_cnt;
        m_cpol = 1'b0; m_cpha = 1'b0; m_cs = 1;
        @(negedge clock);
        clk_ratio = 8'd0; cpol = 1'b0; cpha = 1'b0; cs_sel = 2'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0; fifo_wren = 1'b1; data_in = w9;
        n_checks++; if (busy !== 1'b1 || data_full !== 1'b1) begin n_fail++; $display("FAIL pp_load: busy %b full %b want 1 1", busy, data_full); end
        exp_q.push_back(w9);
        @(negedge clock);
        fifo_wren = 1'b0;
        n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL pp_count: got %0d want 8", fifo_count); end
        wait_done(db);
        n_checks++; if (obs_n - ob != FD + 1) begin n_fail++; $display("FAIL pp_words: got %0d want %0d", obs_n - ob, FD + 1); end
        for (int i = 0; i < FD + 1; i++) begin
            n_checks++; if (obs_w[(ob + i) % 64] !== exp_q[i]) begin n_fail++; $display("FAIL pp_word%0d: got %h want %h", i, obs_w[(ob + i) % 64], exp_q[i]); end
        end
        n_checks++; if (done_cnt - db != 1) begin n_fail++; $display("FAIL pp_done: got %0d pulses want 1", done_cnt - db); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_modes();
        test_reset_mid();
        test_push_pop();
        n_checks++; if (sen_bad != 0) begin n_fail++; $display("FAIL sen_select: %0d cycles with a wrong SEN pattern, want 0", sen_bad); end
        n_checks++; if (idle_bad != 0) begin n_fail++; $display("FAIL idle_sdata: %0d idle cycles with SDATA high, want 0", idle_bad); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
